sar_ctrl: RTL and testbench
===========================

// Module: sar_ctrl
// PURPOSE
//  Successive-approximation control FSM for the 9-bit SAR ADC. Sits directly upstream of the
//  output latch. Drives the sampling switch and the P/N capacitor-DAC switch words from the
//  comparator decision, one bit per clock, MSB (index 0) first. Asserts FINAL when the code is
//  complete, so the downstream latch captures SWP on the FINAL rising edge.
// PARAMETERS
//  NBITS          9   resolution; number of conversion cycles and width of SWP/SWN
//  SAMPLE_CYCLES  2   clock cycles SMP is held high (track phase), legal range 1..15
// PORTS
//  CKS    in   1      conversion clock; all state updates on rising edge
//  EN     in   1      asynchronous active-low reset; low = block cleared and held idle
//  START  in   1      request one conversion; sampled on the rising CKS edge in IDLE only
//  CONT   in   1      continuous mode; when high, DONE goes straight back to SAMPLE
//  COMP   in   1      comparator decision; 1 = VP > VN; sampled every CONV-cycle edge
//  SMP    out  1      bootstrap sampling switch enable (track when 1)
//  SWP    out  NBITS  P-side DAC switch word [0:NBITS-1], index 0 = MSB; also the output code
//  SWN    out  NBITS  N-side DAC switch word [0:NBITS-1], index 0 = MSB
//  BUSY   out  1      high from START acceptance until return to IDLE
//  FINAL  out  1      conversion complete strobe; one CKS cycle wide
// BEHAVIOUR
//  Reset:
//  - EN low, asynchronous: state=IDLE; SMP=0, SWP=0, SWN=0, BUSY=0, FINAL=0; counters=0.
//  - EN low mid-conversion aborts immediately, with no FINAL pulse.
//  - The first START is accepted on the first rising edge after EN rises.
//  Outputs:
//  - All outputs are registered; none is combinational from an input.
//  States: IDLE -> SAMPLE -> CONV -> DONE -> IDLE (or -> SAMPLE when CONT=1).
//  IDLE:
//  - SMP=0, BUSY=0, FINAL=0; SWP/SWN hold the last code.
//  - Edge with START=1 -> SAMPLE; SMP<=1, BUSY<=1, SWP<=0, SWN<=0, scnt<=0.
//  SAMPLE:
//  - scnt increments each edge.
//  - Edge where scnt==SAMPLE_CYCLES-1 -> CONV; SMP<=0, k<=0.
//  - SMP is high for exactly SAMPLE_CYCLES cycles.
//  CONV:
//  - Each edge captures COMP for bit k: COMP=1 -> SWP[k]<=1, SWN[k]<=0; COMP=0 -> SWP[k]<=0,
//    SWN[k]<=1. Then k<=k+1.
//  - Undecided bits (index > k) stay 0 on both words.
//  - Decided bits always have SWN[i] == ~SWP[i].
//  - Edge deciding bit NBITS-1 -> DONE, FINAL<=1.
//  DONE (one cycle):
//  - FINAL=1, SWP/SWN stable and complete.
//  - Next edge: FINAL<=0; CONT=1 -> SAMPLE (as from IDLE with START); else -> IDLE, BUSY<=0.
//  Latency (START edge = e0):
//  - SMP high after e0..eS (S=SAMPLE_CYCLES).
//  - Bits decided at e(S+1)..e(S+NBITS).
//  - FINAL high after e(S+NBITS), low after e(S+NBITS+1).
//  - Default: FINAL rises at e11. Throughput in CONT = S+NBITS+1 cycles per code.
//  Ignored / held inputs:
//  - START is ignored outside IDLE; no queuing. START held high in IDLE restarts every
//    return to IDLE.
//  - CONT is sampled only in DONE.
//  - SWP/SWN/code hold after DONE until the next SAMPLE entry clears them, so the code is
//    valid while FINAL is high and afterwards.
//  - COMP is don't-care outside CONV.
//  Counters:
//  - k is ceil(log2(NBITS+1)) bits; scnt is 4 bits. Neither wraps within legal parameter
//    ranges.
// TESTING
//  - T1: EN=0 with random inputs -> SMP=SWP=SWN=BUSY=FINAL=0. Release EN, START=1 at e0 ->
//    SMP=1 after e0, SMP=0 after e2.
//  - T2: COMP seq 1,0,1,1,0,0,1,0,1 -> SWP=101100101, SWN=010011010, FINAL=1 only between
//    e11 and e12, BUSY=0 after e12.
//  - T3: COMP all 1 -> SWP=111111111, SWN=0. COMP all 0 -> SWP=0, SWN=111111111. Each
//    intermediate cycle shows only decided bits set.
//  - T4: START pulsed at e4 and e9 during conversion -> ignored; exactly one FINAL at e11;
//    code unaffected.
//  - T5: CONT=1 with START once -> FINAL pulses at e11, e23, e35; SMP re-asserts after e12.
//    CONT=0 at DONE -> IDLE.
//  - T6: EN low at e7 mid-CONV -> all outputs 0 asynchronously, no FINAL. EN high, START ->
//    clean conversion from SAMPLE.

Source files
------------

// File: rtl/sar_ctrl.sv
// Successive-approximation control FSM for the 9-bit SAR ADC.
// Drives the sampling switch and the P/N capacitor-DAC switch words, one decided bit per clock, MSB first.
module sar_ctrl #(
    parameter int unsigned NBITS         = 9,
    parameter int unsigned SAMPLE_CYCLES = 2
) (
    input  logic             CKS,
    input  logic             EN,
    input  logic             START,
    input  logic             CONT,
    input  logic             COMP,
    output logic             SMP,
    output logic [0:NBITS-1] SWP,
    output logic [0:NBITS-1] SWN,
    output logic             BUSY,
    output logic             FINAL
);

    localparam int unsigned KW = $clog2(NBITS + 1);
    localparam int unsigned SW = 4;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONV,
        DONE
    } state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [SW-1:0] scnt;

    // EN doubles as the asynchronous clear, so dropping it mid-conversion aborts without a FINAL pulse.
    always_ff @(posedge CKS or negedge EN) begin
        if (!EN) begin
            state <= IDLE;
            SMP   <= 1'b0;
            SWP   <= '0;
            SWN   <= '0;
            BUSY  <= 1'b0;
            FINAL <= 1'b0;
            k     <= '0;
            scnt  <= '0;
        end else begin
            FINAL <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state <= SAMPLE;
                        SMP   <= 1'b1;
                        BUSY  <= 1'b1;
                        SWP   <= '0;
                        SWN   <= '0;
                        scnt  <= '0;
                    end
                end
                SAMPLE: begin
                    scnt <= scnt + SW'(1);
                    if (scnt == SW'(SAMPLE_CYCLES - 1)) begin
                        state <= CONV;
                        SMP   <= 1'b0;
                        k     <= '0;
                    end
                end
                CONV: begin
                    SWP[k] <= COMP;
                    SWN[k] <= ~COMP;
                    k      <= k + KW'(1);
                    if (k == KW'(NBITS - 1)) begin
                        state <= DONE;
                        FINAL <= 1'b1;
                    end
                end
                DONE: begin
                    // Continuous mode re-enters sampling exactly as a fresh START would.
                    if (CONT) begin
                        state <= SAMPLE;
                        SMP   <= 1'b1;
                        SWP   <= '0;
                        SWN   <= '0;
                        scnt  <= '0;
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_ctrl.sv
// Randomized self-checking bench for sar_ctrl against a conversion-timeline reference model.
module tb_sar_ctrl;

    localparam int unsigned NB = 9;
    localparam int unsigned S  = 2;

    logic          cks;
    logic          en;
    logic          start;
    logic          cont;
    logic          comp;
    logic          smp;
    logic [0:NB-1] swp;
    logic [0:NB-1] swn;
    logic          busy;
    logic          final_o;

    int            checks;
    int            errors;
    logic [0:NB-1] last_code;

    sar_ctrl #(.NBITS(NB), .SAMPLE_CYCLES(S)) dut (
        .CKS  (cks),
        .EN   (en),
        .START(start),
        .CONT (cont),
        .COMP (comp),
        .SMP  (smp),
        .SWP  (swp),
        .SWN  (swn),
        .BUSY (busy),
        .FINAL(final_o)
    );

    initial cks = 1'b0;
    always #5 cks = ~cks;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word with the first n bits of code decided (optionally inverted), the rest still zero.
    function automatic logic [0:NB-1] partial(input logic [0:NB-1] code, input int n, input bit inv);
        logic [0:NB-1] r;
        r = '0;
        for (int i = 0; i < int'(NB); i++)
            if (i < n) r[i] = inv ? ~code[i] : code[i];
        return r;
    endfunction

    task automatic check_outs(input string tag, input logic smp_e, input logic [0:NB-1] swp_e,
                              input logic [0:NB-1] swn_e, input logic busy_e, input logic fin_e);
        check({tag, ".smp"},   32'(smp),     32'(smp_e));
        check({tag, ".swp"},   32'(swp),     32'(swp_e));
        check({tag, ".swn"},   32'(swn),     32'(swn_e));
        check({tag, ".busy"},  32'(busy),    32'(busy_e));
        check({tag, ".final"}, 32'(final_o), 32'(fin_e));
    endtask

    // One conversion from the START edge (t=0) through the DONE edge (t=S+NB+1).
    // When chained, edge 0 already happened as the previous DONE edge in continuous mode.
    task automatic convert(input string tag, input logic [0:NB-1] code, input bit cont_done,
                           input bit chained);
        int decided;
        for (int t = chained ? 1 : 0; t <= int'(S + NB + 1); t++) begin
            start = (t == 0) ? 1'b1 : 1'($urandom);
            cont  = (t == int'(S + NB + 1)) ? cont_done : 1'($urandom);
            comp  = (t >= int'(S + 1) && t <= int'(S + NB)) ? code[t - int'(S) - 1] : 1'($urandom);
            @(posedge cks);
            #1;
            if (t == int'(S + NB + 1)) begin
                if (cont_done) check_outs($sformatf("%s.e%0d", tag, t), 1'b1, '0, '0, 1'b1, 1'b0);
                else check_outs($sformatf("%s.e%0d", tag, t), 1'b0, code, ~code, 1'b0, 1'b0);
            end else begin
                decided = (t <= int'(S)) ? 0 : t - int'(S);
                check_outs($sformatf("%s.e%0d", tag, t), t < int'(S), partial(code, decided, 1'b0),
                           partial(code, decided, 1'b1), 1'b1, t == int'(S + NB));
            end
        end
        last_code = code;
        start     = 1'b0;
    endtask

    task automatic idle_hold(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            cont  = 1'($urandom);
            comp  = 1'($urandom);
            @(posedge cks);
            #1;
            check_outs($sformatf("%s.i%0d", tag, i), 1'b0, last_code,
                       (last_code == '0 && swn == '0) ? '0 : ~last_code, 1'b0, 1'b0);
        end
    endtask

    task automatic reset_hold(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'($urandom);
            cont  = 1'($urandom);
            comp  = 1'($urandom);
            @(posedge cks);
            #1;
            check_outs($sformatf("%s.r%0d", tag, i), 1'b0, '0, '0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [0:NB-1] code;
        bit            prev_cont;
        bit            c;

        checks    = 0;
        errors    = 0;
        en        = 1'b0;
        start     = 1'b0;
        cont      = 1'b0;
        comp      = 1'b0;
        last_code = '0;

        // Held in reset with random inputs, then the first START right after release.
        reset_hold("t1", 4);
        en = 1'b1;
        convert("t2", 9'b101100101, 1'b0, 1'b0);
        check("t2.swn_code", 32'(swn), 32'(9'b010011010));
        idle_hold("t2", 3);

        convert("t3a", '1, 1'b0, 1'b0);
        convert("t3b", '0, 1'b0, 1'b0);
        idle_hold("t3", 2);

        // Continuous mode: FINAL every S+NB+1 cycles, stop when CONT is low at DONE.
        convert("t5a", 9'b110010011, 1'b1, 1'b0);
        convert("t5b", 9'b001101100, 1'b1, 1'b1);
        convert("t5c", 9'b011110001, 1'b0, 1'b1);
        idle_hold("t5", 2);

        prev_cont = 1'b0;
        for (int n = 0; n < 16; n++) begin
            code = NB'($urandom);
            c    = (n == 15) ? 1'b0 : 1'($urandom);
            convert($sformatf("rnd%0d", n), code, c, prev_cont);
            prev_cont = c;
            if (!c && $urandom_range(0, 1) == 1) idle_hold($sformatf("rnd%0d", n), 2);
        end

        // Abort mid-conversion with EN low between edges.
        start = 1'b1;
        comp  = 1'b1;
        for (int t = 0; t < 7; t++) begin
            @(posedge cks);
            #1;
            start = 1'b0;
        end
        check("t6.busy_pre", 32'(busy), 32'(1'b1));
        #2 en = 1'b0;
        #1;
        check_outs("t6.async", 1'b0, '0, '0, 1'b0, 1'b0);
        reset_hold("t6", 3);
        en        = 1'b1;
        last_code = '0;
        convert("t6c", NB'($urandom), 1'b0, 1'b0);
        idle_hold("t6", 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
